// File: rtl/quad_pkg.sv
// Shared quadrature definitions: phase encodings, FSM state type and
// forward/reverse phase stepping helpers used by the emulator and counter checker.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } quad_state_e;

    // Forward order, as {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] quad_next_phase(input logic [1:0] ph);
        case (ph)
            PH_00:   return PH_10;
            PH_10:   return PH_11;
            PH_11:   return PH_01;
            default: return PH_00;
        endcase
    endfunction

    function automatic logic [1:0] quad_prev_phase(input logic [1:0] ph);
        case (ph)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module quad_step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator stepping a 32-bit position toward a commanded target.
// Optional index output encZ is built only when QUAD_INDEX_EN is defined.
module quad_encoder_emulator
    import quad_pkg::*;
#(
    parameter int COUNTS_PER_REV = 2048,
    parameter int MIN_PERIOD     = 4
) (
    input  logic        CLK_50,
    input  logic        reset,
    input  logic [31:0] target_count,
    input  logic        target_valid,
    input  logic [15:0] step_period,
    output logic        encA,
    output logic        encB,
    output logic [31:0] position,
    output logic        step_pulse,
    output logic        busy
`ifdef QUAD_INDEX_EN
    ,
    output logic        encZ
`endif
);

    localparam logic [15:0] MIN_PER = 16'(MIN_PERIOD);

    if ((COUNTS_PER_REV < 2) || ((COUNTS_PER_REV & (COUNTS_PER_REV - 1)) != 0)) begin : g_bad_cpr
        $error("COUNTS_PER_REV must be a power of two");
    end

    quad_state_e state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] position_q, position_d;
    logic [31:0] target_q, target_d;
    logic        step_pulse_q, step_pulse_d;
    logic        busy_q, busy_d;

    logic        timer_load;
    logic        timer_expired;
    logic [15:0] eff_period;
    logic [15:0] timer_val;
    logic [31:0] diff;
    logic        at_target;

    assign eff_period = (step_period < MIN_PER) ? MIN_PER : step_period;
    assign timer_val  = eff_period - 16'd1;
    // Sign of the wrapped difference picks the shortest path around the ring
    assign diff       = target_q - position_q;
    assign at_target  = (position_q == target_q);

    quad_step_timer #(.W(16)) u_timer (
        .clk      (CLK_50),
        .rst_n    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        position_d   = position_q;
        target_d     = target_valid ? target_count : target_q;
        step_pulse_d = 1'b0;
        busy_d       = !at_target;
        timer_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!at_target) begin
                    timer_load = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (timer_expired) begin
                    if (!at_target) begin
                        step_pulse_d = 1'b1;
                        timer_load   = 1'b1;
                        if (diff[31]) begin
                            phase_d    = quad_prev_phase(phase_q);
                            position_d = position_q - 32'd1;
                        end else begin
                            phase_d    = quad_next_phase(phase_q);
                            position_d = position_q + 32'd1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            phase_q      <= PH_00;
            position_q   <= '0;
            target_q     <= '0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            position_q   <= position_d;
            target_q     <= target_d;
            step_pulse_q <= step_pulse_d;
            busy_q       <= busy_d;
        end
    end

    assign encA       = phase_q[1];
    assign encB       = phase_q[0];
    assign position   = position_q;
    assign step_pulse = step_pulse_q;
    assign busy       = busy_q;

`ifdef QUAD_INDEX_EN
    localparam int IDX_W = $clog2(COUNTS_PER_REV);

    logic encZ_q, encZ_d;

    // Derived from the next-state values so encZ lines up with the A/B phase it marks
    assign encZ_d = (position_d[IDX_W-1:0] == '0) && (phase_d == PH_00);

    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            encZ_q <= 1'b0;
        end else begin
            encZ_q <= encZ_d;
        end
    end

    assign encZ = encZ_q;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator: directed moves plus a random
// target sweep, checked against a quadrature decoder and target model.
`timescale 1ns/1ps
module tb_quad_encoder_emulator;

    logic        CLK_50 = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] target_count = '0;
    logic        target_valid = 1'b0;
    logic [15:0] step_period  = 16'd4;
    logic        encA, encB, step_pulse, busy;
    logic [31:0] position;
`ifdef QUAD_INDEX_EN
    logic        encZ;
`endif

    quad_encoder_emulator #(.COUNTS_PER_REV(2048), .MIN_PERIOD(4)) dut (
        .CLK_50       (CLK_50),
        .reset        (reset),
        .target_count (target_count),
        .target_valid (target_valid),
        .step_period  (step_period),
        .encA         (encA),
        .encB         (encB),
        .position     (position),
        .step_pulse   (step_pulse),
        .busy         (busy)
`ifdef QUAD_INDEX_EN
        ,
        .encZ         (encZ)
`endif
    );

    always #10 CLK_50 = ~CLK_50;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] model_pos  = '0;
    logic [31:0] mdl_tgt    = '0;
    logic [31:0] dec_offset = '0;
    logic [31:0] dec_cnt    = '0;
    logic [1:0]  ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic int idx_of(input logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            if (ph_tab[i] == p) return i;
        end
        return 0;
    endfunction

    // Loop-back decoder: counts edges from encA/encB alone and checks each edge
    initial begin : decoder
        logic [1:0]  prev;
        logic [1:0]  cur;
        logic        changed;
        logic [31:0] here;
        logic [31:0] dd;
        logic [31:0] exp_next;
        int          d;
        prev = 2'b00;
        forever begin
            @(negedge CLK_50);
            cur = {encA, encB};
            if (!reset) begin
                dec_cnt = '0;
                prev    = 2'b00;
            end else begin
                changed = (cur != prev);
                if (changed || step_pulse)
                    check("pulse_vs_edge", 32'(step_pulse), 32'(changed));
                if (changed) begin
                    d    = (idx_of(cur) - idx_of(prev)) & 3;
                    check("single_transition", 32'(d != 2), 32'd1);
                    here = dec_cnt + dec_offset;
                    dd   = mdl_tgt - here;
                    exp_next = dd[31] ? here - 32'd1 : here + 32'd1;
                    dec_cnt  = (d == 1) ? dec_cnt + 32'd1 : dec_cnt - 32'd1;
                    check("direction", dec_cnt + dec_offset, exp_next);
                    check("position_track", position, dec_cnt + dec_offset);
                    check("phase_abs", 32'(cur), 32'(ph_tab[(dec_cnt + dec_offset) & 32'd3]));
                    prev = cur;
                end
            end
        end
    end

    initial begin : watchdog
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_move(input logic [31:0] tgt, input logic [15:0] per);
        int          eff, n_exp, seen, last, cyc;
        logic [31:0] d;
        eff   = (per < 16'd4) ? 4 : int'(per);
        d     = tgt - model_pos;
        n_exp = d[31] ? int'(-d) : int'(d);
        @(negedge CLK_50);
        target_count = tgt;
        step_period  = per;
        target_valid = 1'b1;
        mdl_tgt      = tgt;
        @(negedge CLK_50);
        target_valid = 1'b0;
        check("busy_pre", 32'(busy), 32'd0);
        cyc = 0; seen = 0; last = 0;
        while (seen < n_exp && cyc < (n_exp + 2) * eff + 8) begin
            @(negedge CLK_50);
            cyc++;
            if (cyc == 1) check("busy_rise", 32'(busy), 32'(n_exp != 0));
            if (step_pulse) begin
                seen++;
                if (seen == 1) check("first_edge_latency", 32'(cyc), 32'(eff + 1));
                else           check("edge_spacing", 32'(cyc - last), 32'(eff));
                last = cyc;
            end
        end
        check("edge_count", 32'(seen), 32'(n_exp));
        if (n_exp > 0) check("busy_at_last_edge", 32'(busy), 32'd1);
        @(negedge CLK_50);
        check("busy_fall", 32'(busy), 32'd0);
        check("final_position", position, tgt);
        model_pos = tgt;
        repeat (eff + 2) @(negedge CLK_50);
    endtask

    task automatic wait_idle(input int budget, output int pulses);
        int c;
        pulses = 0;
        c = 0;
        repeat (2) begin
            @(negedge CLK_50);
            if (step_pulse) pulses++;
        end
        while (busy && c < budget) begin
            @(negedge CLK_50);
            c++;
            if (step_pulse) pulses++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic deposit(input logic [31:0] v);
        @(posedge CLK_50);
        #2;
        dut.position_q = v;
        dut.target_q   = v;
        dec_offset     = dec_offset + (v - model_pos);
        model_pos      = v;
        mdl_tgt        = v;
    endtask

    task automatic pulse_reset();
        @(negedge CLK_50);
        reset = 1'b0;
        model_pos = '0; mdl_tgt = '0; dec_offset = '0;
        repeat (2) @(negedge CLK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLK_50);
    endtask

    initial begin : stimulus
        int          p, c, delta, n;
        logic [31:0] tgt;
        logic [15:0] per;

        repeat (3) @(negedge CLK_50);
        check("reset_hold_pos", position, 32'd0);
        reset = 1'b1;
        @(negedge CLK_50);
        check("reset_ab", 32'({encA, encB}), 32'd0);
        check("reset_position", position, 32'd0);
        check("reset_step_pulse", 32'(step_pulse), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 0 -> 5 at period 10
        do_move(32'd5, 16'd10);
        check("t1_phase", 32'({encA, encB}), 32'h2);

        // 0 -> -3 with period clamped to 4
        pulse_reset();
        do_move(32'hFFFF_FFFD, 16'd2);
        check("t2_phase", 32'({encA, encB}), 32'h2);

        // Wrap across the signed boundary
        do_move(32'd2, 16'd4);
        deposit(32'h7FFF_FFFE);
        do_move(32'h8000_0001, 16'd5);
        check("t3_phase", 32'({encA, encB}), 32'h2);

        // Retarget 100 -> 90 while passing 95
        deposit(32'd85);
        @(negedge CLK_50);
        target_count = 32'd100; step_period = 16'd4; target_valid = 1'b1; mdl_tgt = 32'd100;
        @(negedge CLK_50);
        target_valid = 1'b0;
        n = 0; c = 0;
        while (!(step_pulse && position == 32'd95) && c < 200) begin
            @(negedge CLK_50);
            c++;
            if (step_pulse) n++;
        end
        check("t4_reach_95", position, 32'd95);
        target_count = 32'd90; target_valid = 1'b1; mdl_tgt = 32'd90;
        @(negedge CLK_50);
        target_valid = 1'b0;
        if (step_pulse) n++;
        wait_idle(200, p);
        check("t4_final", position, 32'd90);
        check("t4_edges", 32'(n + p), 32'd15);
        model_pos = 32'd90;
        repeat (8) @(negedge CLK_50);

        // Asynchronous reset mid-motion
        @(negedge CLK_50);
        target_count = 32'd110; target_valid = 1'b1; mdl_tgt = 32'd110;
        @(negedge CLK_50);
        target_valid = 1'b0;
        repeat (12) @(negedge CLK_50);
        #3 reset = 1'b0;
        #1;
        check("rst_mid_position", position, 32'd0);
        check("rst_mid_ab", 32'({encA, encB}), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_pulse", 32'(step_pulse), 32'd0);
        model_pos = '0; mdl_tgt = '0; dec_offset = '0;
        repeat (2) @(negedge CLK_50);
        reset = 1'b1;
        repeat (3) @(negedge CLK_50);
        check("rst_release_busy", 32'(busy), 32'd0);
        check("rst_release_position", position, 32'd0);

        // Random sweep with loop-back comparison at every idle point
        for (int i = 0; i < 1000; i++) begin
            delta = int'($urandom_range(0, 12)) - 6;
            tgt   = model_pos + 32'(delta);
            per   = 16'($urandom_range(0, 7));
            @(negedge CLK_50);
            target_count = tgt; step_period = per; target_valid = 1'b1; mdl_tgt = tgt;
            @(negedge CLK_50);
            target_valid = 1'b0;
            wait_idle(200, p);
            check("sweep_position", position, tgt);
            check("sweep_edges", 32'(p), 32'((delta < 0) ? -delta : delta));
            check("sweep_loopback", position, dec_cnt + dec_offset);
            model_pos = tgt;
        end

`ifdef QUAD_INDEX_EN
        begin : index_test
            logic [31:0] zq [$];
            pulse_reset();
            @(negedge CLK_50);
            target_count = 32'd4100; step_period = 16'd4; target_valid = 1'b1; mdl_tgt = 32'd4100;
            @(negedge CLK_50);
            target_valid = 1'b0;
            c = 0;
            while ((busy || c < 3) && c < 20000) begin
                @(negedge CLK_50);
                c++;
                if (encZ && (zq.size() == 0 || zq[$] != position)) zq.push_back(position);
            end
            check("idx_final", position, 32'd4100);
            check("idx_count", 32'(zq.size()), 32'd3);
            if (zq.size() == 3) begin
                check("idx_0", zq[0], 32'd0);
                check("idx_1", zq[1], 32'd2048);
                check("idx_2", zq[2], 32'd4096);
            end
        end
`endif

        repeat (4) @(negedge CLK_50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
